// File: rtl/systolic_ws_controller.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ws_controller
// Function : Sequencer for a ROWS x COLS weight-stationary systolic array.
//            Drives PE control codes, buffer read strobes and result flags.
//            Optional weight reuse: define SA_CTRL_WEIGHT_REUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ws_controller #(
  parameter int WORD_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [15:0]               num_vectors,
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  input  logic                      reuse_w,
`endif
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [2*ROWS-1:0]         row_ctrl,
  output logic                      top_d_sel,
  output logic                      w_rd_en,
  output logic [$clog2(ROWS)-1:0]   w_rd_addr,
  output logic                      a_rd_en,
  output logic [15:0]               a_rd_addr,
  output logic [ROWS-1:0]           row_a_valid,
  output logic                      out_valid,
  output logic [15:0]               out_idx
);

  localparam int              c_AW        = $clog2(ROWS);
  localparam logic [1:0]      c_PE_IDLE   = 2'b00;
  localparam logic [1:0]      c_PE_WEIGHT = 2'b01;
  localparam logic [1:0]      c_PE_MULT   = 2'b10;
  localparam logic [c_AW-1:0] c_LAST_ROW  = c_AW'(ROWS - 1);

  if (ROWS < 2 || COLS < 1 || WORD_WIDTH < 1) begin : g_param_check
    $error("systolic_ws_controller: invalid array geometry");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [16:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_num, w_num;
  logic [16:0] w_last_k;
  logic        w_accept, w_zero_done, w_skip_load;
  logic [1:0]  w_idle_code;

  logic                  w_busy_nxt, w_done_nxt, w_top_sel_nxt, w_wen_nxt;
  logic                  w_aen_nxt, w_ov_nxt;
  logic [2*ROWS-1:0]     w_row_ctrl_nxt;
  logic [c_AW-1:0]       w_waddr_nxt;
  logic [15:0]           w_aaddr_nxt, w_oidx_nxt;
  logic [ROWS-1:0]       w_rav_nxt;

  // True when off <= k < n + off, evaluated without wrap at k up to 2^17-1.
  function automatic logic in_window(input logic [16:0] k, input int unsigned off,
                                     input logic [15:0] n);
    logic [17:0] d;
    d = {1'b0, k} - 18'(off);
    return !d[17] && (d[16:0] < {1'b0, n});
  endfunction

`ifdef SA_CTRL_WEIGHT_REUSE_EN
  localparam logic [1:0] c_PE_HOLD = 2'b11;
  logic r_w_loaded, w_w_loaded_nxt;

  assign w_skip_load = reuse_w & r_w_loaded;
  assign w_idle_code = w_w_loaded_nxt ? c_PE_HOLD : c_PE_IDLE;

  always_comb begin
    w_w_loaded_nxt = r_w_loaded;
    if (abort)
      w_w_loaded_nxt = 1'b0;
    else if (r_state == S_LOAD && w_state_nxt == S_COMPUTE)
      w_w_loaded_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_w_loaded <= 1'b0;
    else          r_w_loaded <= w_w_loaded_nxt;
  end
`else
  assign w_skip_load = 1'b0;
  assign w_idle_code = c_PE_IDLE;
`endif

  assign w_num    = w_accept ? num_vectors : r_num;
  assign w_last_k = {1'b0, r_num} + 17'(ROWS + COLS - 2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_zero_done = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_vectors == 16'd0) begin
              w_zero_done = 1'b1;
            end else begin
              w_accept    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = w_skip_load ? S_COMPUTE : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (r_cnt == 17'(ROWS - 1)) begin
            w_state_nxt = S_COMPUTE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 17'd1;
          end
        end
        S_COMPUTE: begin
          if (r_cnt == w_last_k) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 17'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear registered in-phase with it.
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_done_nxt     = w_zero_done | (w_state_nxt == S_DONE);
    w_row_ctrl_nxt = {ROWS{w_idle_code}};
    w_top_sel_nxt  = 1'b0;
    w_wen_nxt      = 1'b0;
    w_waddr_nxt    = w_rd_addr;
    w_aen_nxt      = 1'b0;
    w_aaddr_nxt    = a_rd_addr;
    w_rav_nxt      = '0;
    w_ov_nxt       = 1'b0;
    w_oidx_nxt     = out_idx;
    case (w_state_nxt)
      S_LOAD: begin
        w_busy_nxt     = 1'b1;
        w_row_ctrl_nxt = {ROWS{c_PE_WEIGHT}};
        w_wen_nxt      = 1'b1;
        w_waddr_nxt    = c_LAST_ROW - w_cnt_nxt[c_AW-1:0];
      end
      S_COMPUTE: begin
        w_busy_nxt     = 1'b1;
        w_row_ctrl_nxt = {ROWS{c_PE_MULT}};
        w_top_sel_nxt  = 1'b1;
        if (in_window(w_cnt_nxt, 0, w_num)) begin
          w_aen_nxt   = 1'b1;
          w_aaddr_nxt = w_cnt_nxt[15:0];
        end
        for (int r = 0; r < ROWS; r++)
          w_rav_nxt[r] = in_window(w_cnt_nxt, r, w_num);
        if (in_window(w_cnt_nxt, ROWS, w_num)) begin
          w_ov_nxt   = 1'b1;
          w_oidx_nxt = w_cnt_nxt[15:0] - 16'(ROWS);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      row_ctrl    <= '0;
      top_d_sel   <= 1'b0;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      a_rd_en     <= 1'b0;
      a_rd_addr   <= '0;
      row_a_valid <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_num       <= w_num;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      row_ctrl    <= w_row_ctrl_nxt;
      top_d_sel   <= w_top_sel_nxt;
      w_rd_en     <= w_wen_nxt;
      w_rd_addr   <= w_waddr_nxt;
      a_rd_en     <= w_aen_nxt;
      a_rd_addr   <= w_aaddr_nxt;
      row_a_valid <= w_rav_nxt;
      out_valid   <= w_ov_nxt;
      out_idx     <= w_oidx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ws_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ws_controller
// Function : Directed self-checking bench for systolic_ws_controller (4x4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ws_controller;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       num_vectors = 16'd0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic              reuse_w = 1'b0;
`endif
  logic              busy, done, top_d_sel, w_rd_en, a_rd_en, out_valid;
  logic [2*ROWS-1:0] row_ctrl;
  logic [1:0]        w_rd_addr;
  logic [15:0]       a_rd_addr, out_idx;
  logic [ROWS-1:0]   row_a_valid;

  int n_checks = 0;
  int n_errors = 0;

  systolic_ws_controller #(.WORD_WIDTH(8), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vectors(num_vectors),
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    .reuse_w(reuse_w),
`endif
    .abort(abort), .busy(busy), .done(done), .row_ctrl(row_ctrl),
    .top_d_sel(top_d_sel), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .row_a_valid(row_a_valid),
    .out_valid(out_valid), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n_done;
    int done_cyc;

    // Reset state
    step(); step();
    check("rst_outputs", {busy, done, row_ctrl, top_d_sel, w_rd_en, w_rd_addr, a_rd_en,
                          row_a_valid, out_valid}, 0);
    check("rst_idx", {a_rd_addr, out_idx}, 0);
    reset_n = 1'b1;
    step();
    check("idle_ctrl", row_ctrl, 0);
    check("idle_busy", busy, 0);

    // Normal run, N = 3: cycle c is the c-th edge after start was raised
    num_vectors = 16'd3;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start = 1'b0;
      if (c <= 4) begin
        check("load_wen", w_rd_en, 1);
        check("load_waddr", w_rd_addr, 4 - c);
        check("load_ctrl", row_ctrl, 8'h55);
        check("load_top", top_d_sel, 0);
      end else begin
        check("wen_off", w_rd_en, 0);
      end
      if (c >= 5 && c <= 14) begin
        check("comp_ctrl", row_ctrl, 8'hAA);
        check("comp_top", top_d_sel, 1);
      end
      if (c >= 15) check("end_ctrl", row_ctrl, 0);
      check("busy", busy, (c <= 14));
      check("done", done, (c == 15));
      check("a_en", a_rd_en, (c >= 5 && c <= 7));
      if (c >= 5 && c <= 7) check("a_addr", a_rd_addr, c - 5);
      check("out_valid", out_valid, (c >= 9 && c <= 11));
      if (c >= 9 && c <= 11) check("out_idx", out_idx, c - 9);
      case (c)
        1:  check("rav_load", row_a_valid, 4'h0);
        5:  check("rav_k0", row_a_valid, 4'h1);
        6:  check("rav_k1", row_a_valid, 4'h3);
        7:  check("rav_k2", row_a_valid, 4'h7);
        8:  check("rav_k3", row_a_valid, 4'hE);
        9:  check("rav_k4", row_a_valid, 4'hC);
        10: check("rav_k5", row_a_valid, 4'h8);
        11: check("rav_k6", row_a_valid, 4'h0);
        default: ;
      endcase
    end

    // N = 0: immediate done, no array activity
    num_vectors = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_strobes", {w_rd_en, a_rd_en}, 0);
    step();
    check("zero_done_clr", done, 0);
    check("zero_busy2", busy, 0);

    // Abort at COMPUTE k = 2
    num_vectors = 16'd3;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
    end
    check("abort_pre_addr", a_rd_addr, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ctrl", row_ctrl, 0);
    check("abort_strobes", {w_rd_en, a_rd_en, out_valid, row_a_valid}, 0);
    n_done = (done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Run after abort, N = 1: done at 2*4+4+1 = 13
    num_vectors = 16'd1;
    start = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start = 1'b0;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    check("post_abort_done_cyc", done_cyc, 13);

    // start held high: one run, second accept one cycle after done
    num_vectors = 16'd2;
    start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (done === 1'b1) n_done++;
      if (c == 14) check("held_done", done, 1);
      if (c == 15) check("held_gap", {busy, w_rd_en}, 2'b00);
      if (c == 16) begin
        check("held_restart_busy", busy, 1);
        check("held_restart_wen", w_rd_en, 1);
        check("held_restart_addr", w_rd_addr, 3);
      end
    end
    check("held_one_done", n_done, 1);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Reset asserted mid-run clears outputs immediately
    num_vectors = 16'd5;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    check("mid_pre_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {busy, done, row_ctrl, top_d_sel, a_rd_en, row_a_valid}, 0);
    step(); step();
    check("mid_rst_done", done, 0);
    reset_n = 1'b1;
    step();
    check("mid_rst_idle", {busy, done, row_ctrl}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_ws_controller.md
# systolic_ws_controller

Sequencer for the ROWS x COLS weight-stationary systolic array. It drives the per-row 2-bit PE control code (00 IDLE, 01 WEIGHT_INPUT, 10 MULTIPLY) at the array's left edge and issues weight-buffer and activation-buffer read strobes and addresses. It also flags when column-0 partial sums leave the bottom row. It sits between the layer scheduler (start/done handshake) and the array edge feeders and collectors.

## Interface
- WORD_WIDTH, 8, PE operand width (informational; no datapath here)
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥1)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- num_vectors  in  16  activation vectors to stream; latched on accepted start
- abort  in  1  synchronous cancel; highest priority after reset
- busy  out  1  high in LOAD and COMPUTE
- done  out  1  one-cycle completion pulse
- row_ctrl  out  2*ROWS  PE control code per row; row r at [2r+1:2r]
- top_d_sel  out  1  top-edge feeder select: 0 = weight word, 1 = zero psum
- w_rd_en  out  1  weight-row read strobe
- w_rd_addr  out  $clog2(ROWS)  weight row index
- a_rd_en  out  1  activation read strobe
- a_rd_addr  out  16  activation vector index
- row_a_valid  out  ROWS  row r activation valid; 0 means the feeder drives zero
- out_valid  out  1  column-0 bottom partial sum valid
- out_idx  out  16  vector index of the current column-0 result

## Operation
- States are IDLE, LOAD, COMPUTE and DONE. All outputs are registered.
- Reset values: all outputs are 0, including row_ctrl = 00 on every row, and the state is IDLE.
- IDLE
  - row_ctrl = 00, which clears the stored weights.
  - start with num_vectors ≠ 0 latches num_vectors and moves to LOAD.
  - start with num_vectors = 0 pulses done one cycle later, with no array activity, and stays in IDLE.
- LOAD, ROWS cycles (i = 0..ROWS-1)
  - row_ctrl = 01 on all rows; top_d_sel = 0; w_rd_en = 1.
  - w_rd_addr = ROWS-1-i. The bottom row's weights enter first and shift down.
  - After cycle ROWS-1, move to COMPUTE.
- COMPUTE, with cycle counter k = 0..N+ROWS+COLS-2 (N = latched num_vectors)
  - row_ctrl = 10 on all rows; top_d_sel = 1.
  - a_rd_en = (k < N); a_rd_addr = k while valid, else held.
  - row_a_valid[r] = (r ≤ k < N+r). The feeder for row r delays row data by r cycles.
  - out_valid = (ROWS ≤ k < N+ROWS); out_idx = k-ROWS. Collectors delay column c by c further cycles.
  - After the last k, move to DONE.
- DONE, one cycle
  - done = 1, busy = 0, row_ctrl = 00, then IDLE.
- The k counter is 17 bits wide; num_vectors up to 65535 must work without wrap.
- start while busy is ignored.
- abort in any state forces IDLE on the next edge: all strobes 0, row_ctrl = 00, no done pulse.
- Arrays and buffers use asynchronous read. Data corresponds to the address in the same cycle.

## Timing
- start accepted at edge t: LOAD is visible t+1..t+ROWS; COMPUTE begins at t+ROWS+1.
- done is high at t+2*ROWS+COLS+N, so total latency start→done is 2*ROWS+COLS+N cycles.
- busy rises at t+1 and falls in the done cycle.
- Control enters column c c cycles after column 0, via the PE control_out chain. The top-edge weight and zero-psum feeders skew column c by c cycles to match.
- Back-to-back runs: start may be asserted in the done cycle, but it is only sampled in the following IDLE cycle.
- Reset asserted mid-run: all outputs go to 0 immediately; no done pulse.

## Configuration
- SA_CTRL_WEIGHT_REUSE_EN
  - Defined: adds input reuse_w (1 bit), sampled with start.
    - start with reuse_w = 1 skips LOAD and goes IDLE→COMPUTE, with latency ROWS+COLS+N.
    - IDLE then drives row_ctrl = 11, which holds weights. This is the PE default branch and requires the matching PE change.
    - The first run after reset always executes LOAD, regardless of reuse_w.
  - Undefined: no reuse_w port; IDLE drives 00; every run loads weights.

## Test plan
- Reset: hold reset_n = 0 → all outputs 0; release → state IDLE, row_ctrl = 0.
- Normal run, ROWS = COLS = 4, N = 3:
  - w_rd_addr 3,2,1,0 on cycles 1–4.
  - a_rd_addr 0,1,2 on cycles 5–7.
  - out_valid on cycles 9–11 with out_idx 0,1,2.
  - done at cycle 15.
- N = 0: start → done pulse on the next cycle; busy, w_rd_en and a_rd_en never assert.
- abort at COMPUTE k = 2 → next cycle IDLE, row_ctrl = 0, no done; a later start runs normally.
- start held high throughout a run → exactly one run; the second accepted start comes one cycle after done.
- With SA_CTRL_WEIGHT_REUSE_EN, second run with reuse_w = 1, N = 2 → no w_rd_en, done ROWS+COLS+2 = 10 cycles after start.
